// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the param_counter block.
// Optional debounce is selected with `define COUNTER_DEBOUNCE_EN (see btn_debounce).
package counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser for the board button, plus an optional stability filter
// enabled by `define COUNTER_DEBOUNCE_EN (otherwise dout follows the synchroniser).
module btn_debounce
  import counter_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk_200mhz,
  input  logic rst,
  input  logic din,
  output logic dout
);

  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("btn_debounce: DEB_CYCLES must be >= 1");
  end

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_200mhz) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

`ifdef COUNTER_DEBOUNCE_EN
  localparam int unsigned DEB_W = cnt_width(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // cnt_q counts consecutive cycles the synchronised input has differed from
  // the accepted level; any agreement restarts the run.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == DEB_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_200mhz) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign dout = stable_q;
`else
  assign dout = sync2_q;
`endif

endmodule

// File: rtl/param_counter.sv
// Button-enabled up/down counter with wrap/saturate boundary handling, tc pulse and LED.
// Define COUNTER_DEBOUNCE_EN to filter the button before it enables counting.
module param_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned MAX_VAL    = (2 ** WIDTH) - 1,
  parameter int unsigned PRESCALE   = 20,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             clk_200mhz,
  input  logic             rst,
  input  logic             button,
  input  logic             mode_sat,
  input  logic             dir_down,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             led_0
);

  if (MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_max_val
    $error("param_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("param_counter: PRESCALE must be >= 1");
  end

  localparam int unsigned      PRE_W    = cnt_width(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);

  logic btn_q;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk_200mhz (clk_200mhz),
    .rst        (rst),
    .din        (button),
    .dout       (btn_q)
  );

  // Free-running prescaler; clear does not touch it so the tick cadence is kept.
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  logic             step;
  dir_e             dir;
  mode_e            mode;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] up_val, dn_val;
  logic             tc_q, tc_d;
  logic             led_q, led_d;

  assign step = tick & btn_q;
  assign dir  = dir_e'(dir_down);
  assign mode = mode_e'(mode_sat);

  // tc flags a wrap, or the step that first lands on the boundary while
  // saturating; a held step at the boundary is silent.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    up_val  = count_q + 1'b1;
    dn_val  = count_q - 1'b1;
    if (clear) begin
      count_d = '0;
    end else if (step) begin
      if (dir == DIR_UP) begin
        if (count_q != MAX_C) begin
          count_d = up_val;
          tc_d    = (mode == MODE_SAT) && (up_val == MAX_C);
        end else if (mode == MODE_WRAP) begin
          count_d = '0;
          tc_d    = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = dn_val;
          tc_d    = (mode == MODE_SAT) && (dn_val == '0);
        end else if (mode == MODE_WRAP) begin
          count_d = MAX_C;
          tc_d    = 1'b1;
        end
      end
    end
    led_d = led_q ^ tc_d;
  end

  always_ff @(posedge clk_200mhz) begin
    if (rst) begin
      pre_q   <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      led_q   <= led_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign led_0 = led_q;

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, count register width in bits.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1, terminal value, legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter PRESCALE, default 20, clk_200mhz cycles per count tick (20 gives a 10 MHz tick), legal range >=1.
REQ-004 SHALL have parameter DEB_CYCLES, default 16, debounce stability length in cycles, legal range >=1.
REQ-005 SHALL have port clk_200mhz  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port button  input  1  asynchronous count-enable from the board pin.
REQ-008 SHALL have port mode_sat  input  1  0 = wrap at boundary, 1 = saturate at boundary.
REQ-009 SHALL have port dir_down  input  1  0 = count up, 1 = count down.
REQ-010 SHALL have port clear  input  1  synchronous count clear.
REQ-011 SHALL have port count  output  WIDTH  registered count value.
REQ-012 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 SHALL have port led_0  output  1  registered LED; toggles on every tc pulse.

Function
REQ-014 SHALL pass button through a 2-flop synchroniser, producing btn_s.
REQ-015 SHALL run a free prescaler counting 0..PRESCALE-1 and assert tick for one cycle when the prescaler equals PRESCALE-1; PRESCALE=1 SHALL assert tick on every cycle.
REQ-016 SHALL use a clock-enable (tick) only; no derived or gated clocks.
REQ-017 SHALL perform a step only in cycles where tick=1 and btn_q=1 (btn_q per REQ-026).
REQ-018 SHALL, on an up step, increment count if count<MAX_VAL; if count==MAX_VAL, load 0 when mode_sat=0 or hold when mode_sat=1.
REQ-019 SHALL, on a down step, decrement count if count>0; if count==0, load MAX_VAL when mode_sat=0 or hold when mode_sat=1.
REQ-020 SHALL assert tc in the cycle following a wrap step, and following the step that first brings count to the boundary in saturate mode; a held (saturated) step SHALL NOT assert tc.
REQ-021 SHALL apply clear=1 as count<=0 with tc<=0 and led_0 unchanged; clear SHALL take priority over a simultaneous step and SHALL NOT reset the prescaler.
REQ-022 SHALL sample mode_sat and dir_down on the step cycle; changes mid-count take effect on the next step.
REQ-023 SHALL keep count within 0..MAX_VAL at all times; WIDTH-bit arithmetic, no carry out.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set count=0, tc=0, led_0=0, prescaler=0, synchroniser and debounce state=0; rst SHALL override clear and step.
REQ-025 SHALL restart cleanly after rst deasserts: the first tick occurs PRESCALE cycles later.

Configuration
REQ-026 SHALL, with COUNTER_DEBOUNCE_EN defined, change btn_q only after btn_s has held a new value for DEB_CYCLES consecutive cycles (button-to-btn_q latency 2+DEB_CYCLES); without the macro, btn_q=btn_s (latency 2) and DEB_CYCLES is ignored.

Structure
REQ-027 SHALL place the direction and mode encodings (DIR_UP/DIR_DOWN, MODE_WRAP/MODE_SAT) in a shared package counter_pkg.
REQ-028 SHALL implement synchroniser plus debounce as sub-module btn_debounce (params DEB_CYCLES; ports clk_200mhz, rst, din, dout).

Verification (WIDTH=5, MAX_VAL=31, PRESCALE=4, DEB_CYCLES=16)
REQ-029 SHALL cover: button held, up, wrap -> count 0..31 one step per 4 cycles, 31->0 then tc=1 for one cycle, led_0 0->1.
REQ-030 SHALL cover: mode_sat=1, up from 30 -> count 31, tc once, further ticks hold 31 with tc=0.
REQ-031 SHALL cover: dir_down=1, wrap mode, count=0, one step -> count 31, tc=1, led_0 toggles.
REQ-032 SHALL cover: clear asserted in the same cycle as a 31->0 wrap step -> count 0, tc=0, led_0 unchanged.
REQ-033 SHALL cover: rst asserted at count=17, led_0=1 -> next cycle count=0, tc=0, led_0=0; first step 4 cycles after rst release.
REQ-034 SHALL cover: 5-cycle button glitch -> no step with COUNTER_DEBOUNCE_EN; step permitted without it.
